fpmul_round_pack: RTL

- Two-stage pipelined rounding and packing stage that sits directly downstream of the FP multiplier.
- Consumes the multiplier's unrounded result (sign, 8-bit biased exponent, 47-bit fraction-plus-GRS field) and its special-case flags.
- Applies the IEEE-754 rounding mode and packs a 32-bit single-precision result plus RISC-V fflags for the FP writeback mux.
- Forwards the exe_p_mux_bus_type control bus in lockstep and exposes per-stage rd/write-enable for the hazard/clear logic.

---
 rtl/riscv_types.sv | 56 +++++
 rtl/fp_round_inc.sv | 30 +++
 rtl/fpmul_round_pack.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_types.sv
// rtl/riscv_types.sv - shared types and constants for the FP round/pack pipeline
package riscv_types;

    localparam int RD_W = 5;

    // Control bus forwarded alongside the datapath to the writeback mux.
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            reg_write;
        logic            FP_reg_write;
        logic [1:0]      wb_sel;
    } exe_p_mux_bus_type;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rm_e;

    // Bit positions inside fflags = {NV,DZ,OF,UF,NX}
    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

    localparam logic [31:0] CANON_NAN  = 32'h7FC00000;
    localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;
    localparam logic [30:0] INF_MAG    = 31'h7F800000;

    // Everything captured by stage A of the round/pack pipeline.
    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [7:0]        exp;
        logic [46:0]       mant;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
        logic              nv;
        logic [2:0]        rm;
        logic              tag;
        exe_p_mux_bus_type bus;
    } stage_a_t;

    typedef struct packed {
        logic              valid;
        logic [31:0]       result;
        logic [4:0]        fflags;
        logic              tag;
        exe_p_mux_bus_type bus;
    } stage_b_t;

endpackage

// File: rtl/fp_round_inc.sv
// rtl/fp_round_inc.sv - rounding increment decision from L/G/S, sign and rounding mode
//
// Ports:
//   lsb, guard, sticky - last kept bit, first dropped bit, OR of remaining dropped bits
//   sign               - sign of the value being rounded
//   rm                 - rounding mode (reserved encodings behave as RNE)
//   inc                - 1 when the truncated magnitude must be incremented
module fp_round_inc
    import riscv_types::*;
(
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    input  logic       sign,
    input  logic [2:0] rm,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (rm)
            RTZ:     inc = 1'b0;
            RDN:     inc = (guard | sticky) & sign;
            RUP:     inc = (guard | sticky) & ~sign;
            RMM:     inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fpmul_round_pack.sv
// rtl/fpmul_round_pack.sv - two-stage rounding and IEEE-754 single packing after the FP multiplier
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   en                    - advance both stages (0 holds)
//   clear                 - clear[1] flushes stage A, clear[0] flushes stage B
//   valid_i .. nv_i       - unrounded multiplier result and special-case flags
//   rm                    - resolved rounding mode
//   P_signal              - side-band tag, forwarded with the result
//   pipeline_signals_i    - control bus, forwarded in lockstep
//   valid_o, result_o     - stage B valid and packed single
//   fflags_o              - {NV,DZ,OF,UF,NX}
//   P_O_signal            - forwarded tag
//   pipeline_signals_o    - control bus at stage B
//   uu_rd, uu_reg_write,
//   uu_FP_reg_write       - {stage A, stage B} destination info for hazard/clear logic
module fpmul_round_pack
    import riscv_types::*;
#(
    parameter int addr_width = 5,
    parameter int num_rds    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [num_rds-1:0]            clear,
    input  logic                          valid_i,
    input  logic                          sign_i,
    input  logic [7:0]                    exp_i,
    input  logic [46:0]                   mant_i,
    input  logic                          is_nan_i,
    input  logic                          is_inf_i,
    input  logic                          is_zero_i,
    input  logic                          nv_i,
    input  logic [2:0]                    rm,
    input  logic                          P_signal,
    input  exe_p_mux_bus_type             pipeline_signals_i,
    output logic                          valid_o,
    output logic [31:0]                   result_o,
    output logic [4:0]                    fflags_o,
    output logic                          P_O_signal,
    output exe_p_mux_bus_type             pipeline_signals_o,
    output logic [addr_width*num_rds-1:0] uu_rd,
    output logic [num_rds-1:0]            uu_reg_write,
    output logic [num_rds-1:0]            uu_FP_reg_write
);

    stage_a_t a_q;
    stage_b_t b_q;
    stage_b_t b_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
        end else if (clear[1]) begin
            a_q <= '0;
        end else if (en) begin
            a_q <= '{valid: valid_i, sign: sign_i, exp: exp_i, mant: mant_i,
                     is_nan: is_nan_i, is_inf: is_inf_i, is_zero: is_zero_i,
                     nv: nv_i, rm: rm, tag: P_signal, bus: pipeline_signals_i};
        end
    end

    logic inc;
    logic sticky;
    logic inexact;
    logic special;
    logic overflow;
    logic to_inf;
    logic [30:0] rounded;

    assign sticky  = |a_q.mant[22:0];
    assign inexact = a_q.mant[23] | sticky;
    assign special = a_q.is_nan | a_q.is_inf | a_q.is_zero;

    fp_round_inc u_round_inc (
        .lsb    (a_q.mant[24]),
        .guard  (a_q.mant[23]),
        .sticky (sticky),
        .sign   (a_q.sign),
        .rm     (a_q.rm),
        .inc    (inc)
    );

    // Carry out of the fraction lands in the exponent field, which handles
    // both 1.111..+ulp renormalisation and subnormal-to-normal promotion.
    assign rounded  = {a_q.exp, a_q.mant[46:24]} + {30'b0, inc};
    assign overflow = (a_q.exp == 8'hFF) || (rounded[30:23] == 8'hFF);

    // Directed modes saturate to max finite unless they round away from zero.
    always_comb begin
        to_inf = 1'b1;
        case (a_q.rm)
            RTZ:     to_inf = 1'b0;
            RDN:     to_inf = a_q.sign;
            RUP:     to_inf = ~a_q.sign;
            default: to_inf = 1'b1;
        endcase
    end

    always_comb begin
        b_d        = '0;
        b_d.valid  = a_q.valid;
        b_d.tag    = a_q.tag;
        b_d.bus    = a_q.bus;
        if (a_q.is_nan) begin
            b_d.result        = CANON_NAN;
            b_d.fflags[FF_NV] = a_q.nv;
        end else if (a_q.is_inf) begin
            b_d.result = {a_q.sign, INF_MAG};
        end else if (a_q.is_zero) begin
            b_d.result = {a_q.sign, 31'b0};
        end else if (overflow) begin
            b_d.result        = {a_q.sign, to_inf ? INF_MAG : MAX_FINITE};
            b_d.fflags[FF_OF] = 1'b1;
            b_d.fflags[FF_NX] = 1'b1;
        end else begin
            b_d.result        = {a_q.sign, rounded};
            b_d.fflags[FF_NX] = inexact;
            b_d.fflags[FF_UF] = inexact & (a_q.exp == 8'h00);
        end
        if (!a_q.valid || special)
            b_d.fflags[FF_NX] = 1'b0;
        if (!a_q.valid)
            b_d.fflags = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
        end else if (clear[0]) begin
            b_q <= '0;
        end else if (en) begin
            b_q <= b_d;
        end
    end

    assign valid_o            = b_q.valid;
    assign result_o           = b_q.result;
    assign fflags_o           = b_q.fflags;
    assign P_O_signal         = b_q.tag;
    assign pipeline_signals_o = b_q.bus;
    assign uu_rd              = {a_q.bus.rd, b_q.bus.rd};
    assign uu_reg_write       = {a_q.bus.reg_write, b_q.bus.reg_write};
    assign uu_FP_reg_write    = {a_q.bus.FP_reg_write, b_q.bus.FP_reg_write};

endmodule
